// File: rtl/bfii.sv
// Radix-2^2 SDF butterfly type II stage: optional -j rotation followed by a radix-2
// add/sub through a single-delay feedback buffer of depth L. One complex sample per
// accepted cycle in and out, one clock of latency, output one bit wider than input.
module bfii #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_POINTS   = 16,
    parameter int unsigned STAGE      = 0,
    localparam int unsigned OUT_WIDTH = DATA_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sync_clr,
    input  logic                        in_val,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    output logic                        out_val,
    output logic signed [OUT_WIDTH-1:0] out_re,
    output logic signed [OUT_WIDTH-1:0] out_im
);

    localparam int unsigned L  = N_POINTS >> (2 * STAGE + 2);
    // Counter spans one full 4L-sample period; top two bits are the t/s control bits.
    localparam int unsigned CW = (L >= 1) ? $clog2(4 * L) : 2;
    localparam int unsigned AW = (L > 1) ? $clog2(L) : 1;

    if (L < 1) begin : g_bad_len
        $error("bfii: N_POINTS >> (2*STAGE+2) must be at least 1");
    end

    logic [CW-1:0]              c_q, c_d;
    logic                       primed_q, primed_d;
    logic                       accepted;
    logic [AW-1:0]              addr;
    logic                       s, t;
    logic signed [OUT_WIDTH-1:0] x_re, x_im;
    logic signed [OUT_WIDTH-1:0] fb_re, fb_im;
    logic signed [OUT_WIDTH-1:0] wr_re, wr_im;
    logic signed [OUT_WIDTH-1:0] res_re, res_im;
    logic signed [OUT_WIDTH-1:0] buf_re_q [0:L-1];
    logic signed [OUT_WIDTH-1:0] buf_im_q [0:L-1];

    // Control decode, rotation, butterfly arithmetic and next-state.
    always_comb begin
        accepted = in_val & ~sync_clr;
        addr     = (L > 1) ? c_q[AW-1:0] : '0;
        s        = c_q[CW-2];
        t        = c_q[CW-1];

        // Multiply by -j in the second half of the butterfly-active quarter pair.
        if (s && t) begin
            x_re = OUT_WIDTH'(in_im);
            x_im = -OUT_WIDTH'(in_re);
        end else begin
            x_re = OUT_WIDTH'(in_re);
            x_im = OUT_WIDTH'(in_im);
        end

        fb_re = buf_re_q[addr];
        fb_im = buf_im_q[addr];

        if (s) begin
            res_re = fb_re + x_re;
            res_im = fb_im + x_im;
            wr_re  = fb_re - x_re;
            wr_im  = fb_im - x_im;
        end else begin
            // Fill phase drains the previous differences while storing the new half.
            res_re = fb_re;
            res_im = fb_im;
            wr_re  = x_re;
            wr_im  = x_im;
        end

        c_d      = c_q;
        primed_d = primed_q;
        if (sync_clr) begin
            c_d      = '0;
            primed_d = 1'b0;
        end else if (accepted) begin
            c_d = c_q + 1'b1;
            if (c_q == CW'(L - 1)) begin
                primed_d = 1'b1;
            end
        end
    end

    // Counter, priming flag and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q      <= '0;
            primed_q <= 1'b0;
            out_val  <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
        end else begin
            c_q      <= c_d;
            primed_q <= primed_d;
            out_val  <= accepted & primed_q;
            if (accepted) begin
                out_re <= res_re;
                out_im <= res_im;
            end
        end
    end

    // Feedback buffer: read-old, write-new at the same address each accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(L); i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else if (accepted) begin
            buf_re_q[addr] <= wr_re;
            buf_im_q[addr] <= wr_im;
        end
    end

endmodule

// File: tb/tb_bfii.sv
// Self-checking bench for bfii (N_POINTS=16, STAGE=0, L=4). A sample-level reference
// model tracks counter, buffer and held outputs; directed scenarios also compare against
// fixed expected sequences.
module tb_bfii;

    localparam int L = 4;

    logic               clk;
    logic               rst;
    logic               sync_clr;
    logic               in_val;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               out_val;
    logic signed [16:0] out_re;
    logic signed [16:0] out_im;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_n;
    int m_acc;
    int m_buf_re [L];
    int m_buf_im [L];
    int m_re, m_im;
    bit m_val;

    int s2_re [16] = '{6, 8, 10, 12, -4, -4, -4, -4, 9, 10, 11, 12, 9, 10, 11, 12};
    int s2_im [16] = '{0, 0, 0, 0, 0, 0, 0, 0, -13, -14, -15, -16, 13, 14, 15, 16};

    bfii #(
        .DATA_WIDTH(16),
        .N_POINTS  (16),
        .STAGE     (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sync_clr(sync_clr),
        .in_val  (in_val),
        .in_re   (in_re),
        .in_im   (in_im),
        .out_val (out_val),
        .out_re  (out_re),
        .out_im  (out_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic m_reset();
        m_n   = 0;
        m_acc = 0;
        m_re  = 0;
        m_im  = 0;
        m_val = 0;
        for (int i = 0; i < L; i++) begin
            m_buf_re[i] = 0;
            m_buf_im[i] = 0;
        end
    endtask

    // One sample of the stage, from the position of the sample within its 4L period.
    task automatic m_step(input bit val, input bit clr, input int re, input int im);
        int pos, quarter, p, xr, xi, fr, fi;
        if (clr) begin
            m_n   = 0;
            m_acc = 0;
            m_val = 0;
        end else if (val) begin
            pos     = m_n % (4 * L);
            quarter = pos / L;
            p       = pos % L;
            if (quarter == 3) begin
                xr = im;
                xi = -re;
            end else begin
                xr = re;
                xi = im;
            end
            fr = m_buf_re[p];
            fi = m_buf_im[p];
            if (quarter == 1 || quarter == 3) begin
                m_re = fr + xr;
                m_im = fi + xi;
                m_buf_re[p] = fr - xr;
                m_buf_im[p] = fi - xi;
            end else begin
                m_re = fr;
                m_im = fi;
                m_buf_re[p] = xr;
                m_buf_im[p] = xi;
            end
            m_val = (m_acc >= L);
            m_acc++;
            m_n++;
        end else begin
            m_val = 0;
        end
    endtask

    task automatic step(input bit val, input bit clr, input int re, input int im);
        in_val   = val;
        sync_clr = clr;
        in_re    = 16'(re);
        in_im    = 16'(im);
        @(posedge clk);
        #1;
        m_step(val, clr, re, im);
        chk("out_val", int'(out_val), int'(m_val));
        chk("out_re", int'(out_re), m_re);
        chk("out_im", int'(out_im), m_im);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Stream 1..20 from frame start, optionally stalling 3 cycles after inputs 6 and 14.
    task automatic run_s2(input bit stalls, input string tag);
        int q_re[$];
        int q_im[$];
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, 1'b0, n, 0);
            if (out_val) begin
                q_re.push_back(int'(out_re));
                q_im.push_back(int'(out_im));
            end
            if (stalls && (n == 6 || n == 14)) begin
                repeat (3) step(1'b0, 1'b0, rnd16(), rnd16());
            end
        end
        chk({tag, "_count"}, q_re.size(), 16);
        for (int k = 0; k < 16 && k < q_re.size(); k++) begin
            chk({tag, "_re"}, q_re[k], s2_re[k]);
            chk({tag, "_im"}, q_im[k], s2_im[k]);
        end
    endtask

    initial begin
        rst      = 1'b0;
        sync_clr = 1'b0;
        in_val   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        m_reset();

        // 1: reset held with random inputs, then idle after release
        repeat (4) begin
            in_val   = 1'($urandom_range(0, 1));
            sync_clr = 1'($urandom_range(0, 1));
            in_re    = 16'(rnd16());
            in_im    = 16'(rnd16());
            @(posedge clk);
            #1;
            chk("rst_val", int'(out_val), 0);
            chk("rst_re", int'(out_re), 0);
            chk("rst_im", int'(out_im), 0);
        end
        sync_clr = 1'b0;
        in_val   = 1'b0;
        #3 rst = 1'b1;
        repeat (5) step(1'b0, 1'b0, rnd16(), rnd16());

        // 2: continuous stream
        run_s2(1'b0, "s2");

        // 3: same stream with stalls
        step(1'b0, 1'b1, 0, 0);
        run_s2(1'b1, "s3");

        // 4: full-scale extremes, both quarters of butterfly
        step(1'b0, 1'b1, 0, 0);
        repeat (4) step(1'b1, 1'b0, 32767, 32767);
        repeat (4) begin
            step(1'b1, 1'b0, 32767, 32767);
            chk("ext_sum_re", int'(out_re), 65534);
            chk("ext_sum_im", int'(out_im), 65534);
        end
        repeat (4) step(1'b1, 1'b0, -32768, -32768);
        repeat (4) begin
            step(1'b1, 1'b0, -32768, -32768);
            chk("ext_rot_re", int'(out_re), -65536);
            chk("ext_rot_im", int'(out_im), 0);
        end
        repeat (4) begin
            step(1'b1, 1'b0, 0, 0);
            chk("ext_diff_re", int'(out_re), 0);
            chk("ext_diff_im", int'(out_im), -65536);
        end

        // 5: sync_clr at input 7, then restart
        step(1'b0, 1'b1, 0, 0);
        for (int n = 1; n <= 6; n++) step(1'b1, 1'b0, n, 0);
        step(1'b1, 1'b1, 7, 0);
        run_s2(1'b0, "s5");

        // 6: asynchronous reset between edges at input 10
        step(1'b0, 1'b1, 0, 0);
        for (int n = 1; n <= 9; n++) step(1'b1, 1'b0, n, 0);
        in_val = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("arst_val", int'(out_val), 0);
        chk("arst_re", int'(out_re), 0);
        chk("arst_im", int'(out_im), 0);
        m_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        run_s2(1'b0, "s6");

        // Randomized traffic with stalls and occasional realignment
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), rnd16(), rnd16());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
